// File: rtl/prog_stream_loader.sv
// Program loader: filters a UART byte stream into brainfuck program memory and zero-pads the remainder.
// Optional bracket-balance checking is compiled in with `define PROG_LOADER_BRACKET_CHECK_EN.
module prog_stream_loader #(
  parameter int PROG_ADDR_WIDTH = 14,
  parameter int PROG_LEN        = 16383
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       load_req,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       prog_we,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  output logic [7:0]                 prog_wr,
  output logic                       loaded,
  output logic                       loading,
  output logic [1:0]                 error,
  output logic [PROG_ADDR_WIDTH:0]   prog_count,
  output logic [1:0]                 fsm_state
);

  localparam int PW = PROG_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] LEN = PW'(PROG_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_PAD, S_DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic          is_cmd;
  logic          is_term;
  logic          room;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
  logic [PW-1:0] depth;
`endif

  always_comb begin
    is_cmd = 1'b0;
    case (rx_data)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_cmd = 1'b1;
      default: is_cmd = 1'b0;
    endcase
  end

  assign is_term   = (rx_data == 8'h00) || (rx_data == 8'h04);
  assign room      = (ptr < LEN);
  assign fsm_state = state;

  // Write strobe is a one-cycle pulse; address and data hold between writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      ptr        <= '0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wr    <= '0;
      loaded     <= 1'b0;
      loading    <= 1'b0;
      error      <= '0;
      prog_count <= '0;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
      depth      <= '0;
`endif
    end else begin
      prog_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_req) begin
            loaded     <= 1'b0;
            error      <= '0;
            ptr        <= '0;
            prog_count <= '0;
            loading    <= 1'b1;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
            depth      <= '0;
`endif
            state      <= S_RECV;
          end
        end
        S_RECV: begin
          if (rx_valid) begin
            if (is_cmd && room) begin
              prog_we    <= 1'b1;
              prog_addr  <= ptr[PROG_ADDR_WIDTH-1:0];
              prog_wr    <= rx_data;
              ptr        <= ptr + 1'b1;
              prog_count <= prog_count + 1'b1;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
              if (rx_data == 8'h5B) begin
                depth <= depth + 1'b1;
              end else if (rx_data == 8'h5D) begin
                // An unmatched close is still stored; depth saturates at zero.
                if (depth == '0) error[1] <= 1'b1;
                else             depth    <= depth - 1'b1;
              end
`endif
            end else if (is_cmd || is_term) begin
              if (is_cmd) error[0] <= 1'b1;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
              if (depth != '0) error[1] <= 1'b1;
`endif
              state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (room) begin
            prog_we   <= 1'b1;
            prog_addr <= ptr[PROG_ADDR_WIDTH-1:0];
            prog_wr   <= 8'h00;
            ptr       <= ptr + 1'b1;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          loading <= 1'b0;
          if (error == 2'b00) loaded <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_stream_loader.md
Name: prog_stream_loader

Overview:
- Upstream stage of the brainfuck CPU core. Consumes the byte stream from the UART receiver and writes the program into program memory (8-bit cells, addresses 0..PROG_LEN-1).
- Filters out non-command characters, ends the load on a terminator, and zero-pads the rest of memory so unused slots execute as nops.
- Asserts `loaded` only after a clean load. This gates `start_req` in the core.

Parameters:
- PROG_ADDR_WIDTH, 14: program memory address width.
- PROG_LEN, 16383: number of program slots. Addresses 0..PROG_LEN-1 are written on every load.

Ports:
- clk  in  1  system clock, single clock domain
- resetn  in  1  asynchronous, active-low reset
- load_req  in  1  level; sampled only in S_IDLE
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- prog_we  out  1  program memory write strobe
- prog_addr  out  PROG_ADDR_WIDTH  program memory address
- prog_wr  out  8  program memory write data
- loaded  out  1  program valid; held until the next load starts
- loading  out  1  high from load start until S_DONE completes
- error  out  2  [0] overflow, [1] bracket imbalance; sticky until the next load starts
- prog_count  out  PROG_ADDR_WIDTH+1  number of command bytes stored by the last load

Behaviour:
- Reset (async, resetn low): all outputs 0; state S_IDLE; write pointer 0; depth 0. Reset mid-load abandons the load with loaded=0.
- Command set: 0x2B +, 0x2D -, 0x3C <, 0x3E >, 0x2E ., 0x2C ,, 0x5B [, 0x5D ].
- Terminators: 0x00 and 0x04 (EOT).
- S_IDLE:
  - load_req=1 → loaded<=0, error<=0, ptr<=0, prog_count<=0, depth<=0, loading<=1 → S_RECV.
- S_RECV:
  - rx_valid with a command byte and ptr<PROG_LEN → prog_we=1, prog_addr=ptr, prog_wr=rx_data. These are registered, so the write appears the cycle after rx_valid. ptr and prog_count then increment.
  - rx_valid with a command byte and ptr==PROG_LEN → error[0]<=1, byte dropped, → S_PAD.
  - rx_valid with a terminator → S_PAD.
  - Any other byte → ignored, no write.
  - load_req is ignored while in S_RECV.
- S_PAD:
  - Each cycle while ptr<PROG_LEN: prog_we=1, prog_addr=ptr, prog_wr=0x00, ptr++.
  - When ptr==PROG_LEN → S_DONE. If the load filled memory exactly, S_PAD lasts one cycle with no writes.
  - rx_valid in S_PAD and S_DONE is ignored.
- S_DONE (one cycle): loading<=0; loaded<=1 only if error==0 → S_IDLE.
- prog_we is never high for two writes to the same address within one load.
- prog_addr holds its last value when prog_we=0.
- Max latency from terminator to loaded: (PROG_LEN − prog_count) + 3 cycles.
- Pointer arithmetic is PROG_ADDR_WIDTH+1 bits wide. The pointer does not wrap.

Optional Feature:
- Macro: PROG_LOADER_BRACKET_CHECK_EN.
- Enabled:
  - A PROG_ADDR_WIDTH+1-bit depth counter increments on a stored '[' and decrements on a stored ']'.
  - ']' at depth 0 → error[1]<=1 (the byte is still stored) and depth stays 0.
  - On the terminator, or on the overflow transition, depth≠0 → error[1]<=1.
  - Any error[1] suppresses loaded, so the core never sees unmatched brackets.
- Disabled: no depth logic; error[1] tied to 0.

Test Plan:
- PROG_LEN=16; stream "+[>]." then 0x04 → writes 0x2B,0x5B,0x3E,0x5D,0x2E at addresses 0–4, then 0x00 at 5–15. Then loaded=1, prog_count=5, error=0.
- PROG_LEN=16; stream "a+\n-\r" then 0x00 → exactly two command writes (addr0=0x2B, addr1=0x2D), then pads 2–15. loaded=1.
- PROG_LEN=4; stream "+++++" (five commands) → four writes, error[0]=1 on the fifth byte, loaded stays 0, loading drops.
- With PROG_LOADER_BRACKET_CHECK_EN, PROG_LEN=8:
  - "[[]" + EOT → error=2'b10, loaded=0.
  - "][" + EOT → error[1]=1.
  - "[]" + EOT → error=0, loaded=1.
- Reset mid-load: after three of six bytes, resetn low for 2 cycles → all outputs 0. A new load_req followed by "+" + EOT → clean load with loaded=1.
- Reload: after a successful load, assert load_req → loaded drops the next cycle. Then "-" + EOT → addr0=0x2D and the old contents are overwritten with zeros.
